alu_ctrl_seq: RTL and testbench

- Parametrised, sequential successor to the combinational ALU control decoder in the KGP-RISC datapath.
- Accepts an (ALUop, fCode, shamt) request over a valid/ready handshake and returns a registered ALU control code.
- Breaks shift operations into a stream of 1-bit shift steps, one per output handshake, so the ALU needs only a single-bit shifter.
- Sits between the main control unit and the ALU.
- Flags illegal encodings instead of emitting a default code.

---
 rtl/alu_ctrl_seq.sv | 152 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Sequential ALU control decoder: captures (ALUop, fCode, shamt) over valid/ready
// and emits the ALU control code, expanding shifts into single-bit steps.
module alu_ctrl_seq #(
    parameter int unsigned OP_W   = 3,
    parameter int unsigned FC_W   = 4,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned SH_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   ALUop,
    input  logic [FC_W-1:0]   fCode,
    input  logic [SH_W-1:0]   shamt,
    output logic [CTRL_W-1:0] ALU_ctrlOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              illegal
);

    localparam logic [CTRL_W-1:0] C_ADD    = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] C_COMP   = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] C_AND    = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] C_XOR    = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] C_SHL1   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] C_SRL1   = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] C_SRA1   = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] C_PASS_B = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] C_PASS_A = CTRL_W'(8);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SINGLE = 2'd1,
        S_SHIFT  = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] code_q;
    logic [SH_W-1:0]   count_q;

    logic [CTRL_W-1:0] dec_code;
    logic              dec_shift;
    logic              dec_illegal;
    logic              capture;
    logic              shamt_zero;

    // Request decode, evaluated on the live inputs while idle
    always_comb begin
        dec_code    = C_ADD;
        dec_shift   = 1'b0;
        dec_illegal = 1'b0;
        if (ALUop == OP_W'(0)) begin
            case (fCode)
                FC_W'(0): dec_code = C_ADD;
                FC_W'(1): dec_code = C_COMP;
                FC_W'(2): dec_code = C_AND;
                FC_W'(3): dec_code = C_XOR;
                FC_W'(4), FC_W'(7): begin dec_code = C_SHL1; dec_shift = 1'b1; end
                FC_W'(5), FC_W'(8): begin dec_code = C_SRL1; dec_shift = 1'b1; end
                FC_W'(6), FC_W'(9): begin dec_code = C_SRA1; dec_shift = 1'b1; end
                default:  dec_illegal = 1'b1;
            endcase
        end else if (ALUop == OP_W'(1)) begin
            dec_code = C_ADD;
        end else if (ALUop == OP_W'(2)) begin
            dec_code = C_COMP;
        end else if (ALUop == OP_W'(3)) begin
            dec_code = C_PASS_B;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    assign capture    = (state == S_IDLE) && in_valid;
    assign shamt_zero = (shamt == SH_W'(0));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (dec_illegal)                   state_nxt = S_ERR;
                    else if (dec_shift && !shamt_zero) state_nxt = S_SHIFT;
                    else                               state_nxt = S_SINGLE;
                end
            end
            S_SINGLE: if (out_ready) state_nxt = S_IDLE;
            S_SHIFT:  if (out_ready && (count_q == SH_W'(1))) state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Captured code and remaining shift steps; a zero-length shift becomes PASS_A
    always_ff @(posedge clk) begin
        if (!rst) begin
            code_q  <= C_ADD;
            count_q <= SH_W'(0);
        end else if (capture && !dec_illegal) begin
            code_q  <= (dec_shift && shamt_zero) ? C_PASS_A : dec_code;
            count_q <= shamt;
        end else if ((state == S_SHIFT) && out_ready) begin
            count_q <= count_q - SH_W'(1);
        end
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        busy       = 1'b0;
        illegal    = 1'b0;
        ALU_ctrlOp = C_ADD;
        case (state)
            S_IDLE: in_ready = 1'b1;
            S_SINGLE: begin
                out_valid  = 1'b1;
                out_last   = 1'b1;
                busy       = 1'b1;
                ALU_ctrlOp = code_q;
            end
            S_SHIFT: begin
                out_valid  = 1'b1;
                out_last   = (count_q == SH_W'(1));
                busy       = 1'b1;
                ALU_ctrlOp = code_q;
            end
            S_ERR: begin
                illegal = 1'b1;
                busy    = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Randomized bench for alu_ctrl_seq against a request-level reference model.
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] ALUop;
    logic [3:0] fCode;
    logic [4:0] shamt;
    logic [3:0] ALU_ctrlOp;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    alu_ctrl_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUop      (ALUop),
        .fCode      (fCode),
        .shamt      (shamt),
        .ALU_ctrlOp (ALU_ctrlOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Request-level model: the code stream a request should produce
    task automatic model(input int op, input int fc, input int sh,
                         output int code, output int steps, output bit ill);
        ill   = 1'b0;
        code  = 0;
        steps = 1;
        if (op == 0) begin
            if (fc <= 3) begin
                code = fc;
            end else if (fc <= 9) begin
                code  = (sh == 0) ? 8 : 4 + (fc - 4) % 3;
                steps = (sh == 0) ? 1 : sh;
            end else begin
                ill = 1'b1;
            end
        end else if (op == 1) code = 0;
        else if (op == 2) code = 1;
        else if (op == 3) code = 7;
        else ill = 1'b1;
    endtask

    // Starts and ends just after a falling edge; mode 0 always ready, 1 random, 2 stall 2 cycles at step 1
    task automatic run_req(input int op, input int fc, input int sh, input int mode);
        int  code, steps, hs, cyc, stall;
        bit  ill, rdy;
        model(op, fc, sh, code, steps, ill);
        chk("idle_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        ALUop     = 3'(op);
        fCode     = 4'(fc);
        shamt     = 5'(sh);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        if (ill) begin
            chk("err_illegal", illegal, 1);
            chk("err_out_valid", out_valid, 0);
            chk("err_busy", busy, 1);
            @(negedge clk);
            chk("err_pulse_end", illegal, 0);
            chk("err_out_valid2", out_valid, 0);
            chk("err_in_ready", in_ready, 1);
        end else begin
            hs    = 0;
            cyc   = 0;
            stall = (mode == 2) ? 2 : 0;
            while (hs < steps && cyc < 400) begin
                chk("out_valid", out_valid, 1);
                chk("code", ALU_ctrlOp, 32'(code));
                chk("last", out_last, 32'(hs == steps - 1));
                chk("busy_in_ready", in_ready, 0);
                if (stall > 0) begin
                    rdy = 1'b0;
                    stall--;
                end else if (mode == 1) begin
                    rdy = 1'($urandom_range(0, 1));
                end else begin
                    rdy = 1'b1;
                end
                out_ready = rdy;
                // requests offered while busy must be ignored
                in_valid = ($urandom_range(0, 3) == 0);
                ALUop    = 3'($urandom);
                fCode    = 4'($urandom);
                shamt    = 5'($urandom);
                @(negedge clk);
                in_valid = 1'b0;
                if (rdy) hs++;
                cyc++;
            end
            chk("handshakes", hs, steps);
            out_ready = 1'b0;
            chk("done_out_valid", out_valid, 0);
            chk("done_busy", busy, 0);
            chk("done_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        int op, fc, sh;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ALUop     = '0;
        fCode     = '0;
        shamt     = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_code", ALU_ctrlOp, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        run_req(0, 0, 0, 0);
        run_req(0, 6, 3, 0);
        run_req(0, 4, 2, 2);
        run_req(0, 8, 0, 0);
        run_req(0, 12, 0, 0);
        run_req(5, 0, 0, 0);
        run_req(3, 0, 9, 0);
        run_req(0, 9, 31, 1);

        // Reset in the middle of a maximum-length shift
        in_valid = 1'b1;
        ALUop    = 3'd0;
        fCode    = 4'd7;
        shamt    = 5'd31;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_code", ALU_ctrlOp, 4);
        chk("mid_last", out_last, 0);
        rst = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b0;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_code", ALU_ctrlOp, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_illegal", illegal, 0);
        chk("mrst_in_ready", in_ready, 1);
        @(negedge clk);
        chk("mrst_discard", out_valid, 0);
        run_req(0, 0, 0, 0);

        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 7));
            fc = int'($urandom_range(0, 15));
            sh = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31))
                                              : int'($urandom_range(0, 4));
            run_req(op, fc, sh, int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
